// File: rtl/cla_pg_cell.sv
// Single-bit propagate/generate cell for the 4-bit carry-lookahead adder.
`timescale 1ns/1ps
module cla_pg_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_p,
  output logic o_g
);

  // Per-bit propagate and generate terms.
  always_comb begin
    o_p = 1'b0;
    o_g = 1'b0;
    o_p = i_a ^ i_b;
    o_g = i_a & i_b;
  end

endmodule

// File: rtl/four_bit_carry_look_ahead_adder.sv
// 4-bit carry-lookahead adder with two-level carries, group P/G for cascading,
// and a registered copy of the result.
`timescale 1ns/1ps
module four_bit_carry_look_ahead_adder (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  input  logic       clk,
  input  logic       rst_n,
  output logic       pg,
  output logic       gg,
  output logic [3:0] sum_q,
  output logic       cout_q
);

  localparam int unsigned WIDTH = 4;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] r_sum_q;
  logic             r_cout_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
    cla_pg_cell u_pg (
      .i_a (in1[gi]),
      .i_b (in2[gi]),
      .o_p (w_p[gi]),
      .o_g (w_g[gi])
    );
  end

  // Lookahead carry unit: every carry is a flat sum-of-products of P, G and cin.
  always_comb begin
    w_c    = 5'b0_0000;
    w_c[0] = cin;
    w_c[1] = w_g[0]
           | (w_p[0] & cin);
    w_c[2] = w_g[1]
           | (w_p[1] & w_g[0])
           | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2]
           | (w_p[2] & w_g[1])
           | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);
    w_c[4] = w_g[3]
           | (w_p[3] & w_g[2])
           | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
  end

  // Sum bits and group terms; group generate excludes cin so blocks can cascade.
  always_comb begin
    sum  = w_p ^ w_c[WIDTH-1:0];
    cout = w_c[WIDTH];
    pg   = &w_p;
    gg   = w_g[3]
         | (w_p[3] & w_g[2])
         | (w_p[3] & w_p[2] & w_g[1])
         | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  end

  // Registered result copy, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q  <= 4'h0;
      r_cout_q <= 1'b0;
    end else begin
      r_sum_q  <= sum;
      r_cout_q <= cout;
    end
  end

  assign sum_q  = r_sum_q;
  assign cout_q = r_cout_q;

endmodule

// File: tb/tb_four_bit_carry_look_ahead_adder.sv
// Directed and exhaustive self-checking bench for four_bit_carry_look_ahead_adder.
`timescale 1ns/1ps
module tb_four_bit_carry_look_ahead_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in1 = 4'h0;
  logic [3:0] in2 = 4'h0;
  logic       cin = 1'b0;
  logic [3:0] sum;
  logic       cout;
  logic       pg;
  logic       gg;
  logic [3:0] sum_q;
  logic       cout_q;

  int checks = 0;
  int errors = 0;

  four_bit_carry_look_ahead_adder dut (
    .in1    (in1),
    .in2    (in2),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .clk    (clk),
    .rst_n  (rst_n),
    .pg     (pg),
    .gg     (gg),
    .sum_q  (sum_q),
    .cout_q (cout_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c);
    in1 = a;
    in2 = b;
    cin = c;
    #0.1;
  endtask

  initial begin
    int exp_total;
    int exp_gg;
    int exp_pg;

    // Reset state and all-zero boundary
    #1;
    check("rst_sum_q", {4'h0, sum_q}, 8'h00);
    check("rst_cout_q", {7'h0, cout_q}, 8'h00);
    check("zero_sum", {4'h0, sum}, 8'h00);
    check("zero_cout", {7'h0, cout}, 8'h00);
    check("zero_pg", {7'h0, pg}, 8'h00);
    check("zero_gg", {7'h0, gg}, 8'h00);

    // 7+8+0 under reset: combinational path live, registers held clear
    apply(4'h7, 4'h8, 1'b0);
    check("rst_comb_sum", {4'h0, sum}, 8'h0F);
    check("rst_comb_cout", {7'h0, cout}, 8'h00);
    check("rst_comb_pg", {7'h0, pg}, 8'h01);
    @(posedge clk); #1;
    check("rst_hold_sum_q", {4'h0, sum_q}, 8'h00);
    check("rst_hold_cout_q", {7'h0, cout_q}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rel_no_edge_sum_q", {4'h0, sum_q}, 8'h00);
    @(posedge clk); #1;
    check("first_cap_sum_q", {4'h0, sum_q}, 8'h0F);
    check("first_cap_cout_q", {7'h0, cout_q}, 8'h00);

    // 15+15+1
    @(negedge clk);
    apply(4'hF, 4'hF, 1'b1);
    check("ff1_sum", {4'h0, sum}, 8'h0F);
    check("ff1_cout", {7'h0, cout}, 8'h01);
    check("ff1_gg", {7'h0, gg}, 8'h01);
    check("ff1_pg", {7'h0, pg}, 8'h00);
    check("ff1_sum_q_before_edge", {4'h0, sum_q}, 8'h0F);
    check("ff1_cout_q_before_edge", {7'h0, cout_q}, 8'h00);
    @(posedge clk); #1;
    check("ff1_sum_q", {4'h0, sum_q}, 8'h0F);
    check("ff1_cout_q", {7'h0, cout_q}, 8'h01);

    // 15+0+1
    @(negedge clk);
    apply(4'hF, 4'h0, 1'b1);
    check("f01_sum", {4'h0, sum}, 8'h00);
    check("f01_cout", {7'h0, cout}, 8'h01);
    check("f01_pg", {7'h0, pg}, 8'h01);
    check("f01_gg", {7'h0, gg}, 8'h00);
    @(posedge clk); #1;
    check("f01_sum_q", {4'h0, sum_q}, 8'h00);
    check("f01_cout_q", {7'h0, cout_q}, 8'h01);

    // A+5+1
    @(negedge clk);
    apply(4'hA, 4'h5, 1'b1);
    check("a51_sum", {4'h0, sum}, 8'h00);
    check("a51_cout", {7'h0, cout}, 8'h01);
    check("a51_pg", {7'h0, pg}, 8'h01);
    check("a51_gg", {7'h0, gg}, 8'h00);

    // 9+9 capture, then asynchronous reset between edges
    @(negedge clk);
    apply(4'h9, 4'h9, 1'b0);
    check("99_sum", {4'h0, sum}, 8'h02);
    check("99_cout", {7'h0, cout}, 8'h01);
    @(posedge clk); #1;
    check("99_sum_q", {4'h0, sum_q}, 8'h02);
    check("99_cout_q", {7'h0, cout_q}, 8'h01);
    #1;
    rst_n = 1'b0;
    #0.1;
    check("async_clr_sum_q", {4'h0, sum_q}, 8'h00);
    check("async_clr_cout_q", {7'h0, cout_q}, 8'h00);
    apply(4'h3, 4'h4, 1'b1);
    check("rst_comb2_sum", {4'h0, sum}, 8'h08);
    check("rst_comb2_cout", {7'h0, cout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("recap_sum_q", {4'h0, sum_q}, 8'h08);
    check("recap_cout_q", {7'h0, cout_q}, 8'h00);

    // Exhaustive sweep of the combinational outputs
    for (int c = 0; c < 2; c++) begin
      for (int v = 0; v < 256; v++) begin
        apply(4'(v >> 4), 4'(v & 15), 1'(c));
        exp_total = (v >> 4) + (v & 15) + c;
        exp_gg    = (((v >> 4) + (v & 15)) > 15) ? 1 : 0;
        exp_pg    = ((((v >> 4) ^ (v & 15)) & 15) == 15) ? 1 : 0;
        check($sformatf("sweep_sum c=%0d a=%0h b=%0h", c, v >> 4, v & 15),
              {3'h0, cout, sum}, 8'(exp_total));
        check($sformatf("sweep_gg c=%0d a=%0h b=%0h", c, v >> 4, v & 15),
              {7'h0, gg}, 8'(exp_gg));
        check($sformatf("sweep_pg c=%0d a=%0h b=%0h", c, v >> 4, v & 15),
              {7'h0, pg}, 8'(exp_pg));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_bit_carry_look_ahead_adder.md
FOUR_BIT_CARRY_LOOK_AHEAD_ADDER -- requirements
Module: four_bit_carry_look_ahead_adder

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-003 clk  input  1  clock for the registered result copy only.
REQ-004 rst_n  input  1  asynchronous active-low reset of all registers.
REQ-005 in1  input  4  operand A, unsigned.
REQ-006 in2  input  4  operand B, unsigned.
REQ-007 cin  input  1  carry-in.
REQ-008 sum  output  4  combinational sum bits [3:0].
REQ-009 cout  output  1  combinational carry-out (sum bit 4).
REQ-010 pg  output  1  group propagate, P3&P2&P1&P0, for cascading.
REQ-011 gg  output  1  group generate, G3|P3G2|P3P2G1|P3P2P1G0, for cascading.
REQ-012 sum_q  output  4  registered sum.
REQ-013 cout_q  output  1  registered carry-out.
REQ-014 Port declaration order SHALL be in1, in2, cin, sum, cout, then clk, rst_n, pg, gg, sum_q, cout_q, so positional instantiation with five connections binds the core adder ports.

Function
REQ-015 {cout,sum} SHALL equal in1 + in2 + cin as a 5-bit unsigned result for all 512 input combinations.
REQ-016 sum/cout/pg/gg SHALL be purely combinational with zero clock latency; they SHALL settle within 0.1 ns of simulation time after an input change (no # delays in RTL).
REQ-017 Per bit i: Gi = in1[i]&in2[i], Pi = in1[i]^in2[i], sum[i] = Pi ^ Ci, with C0 = cin.
REQ-018 Carries C1..C4 SHALL each be computed directly by two-level lookahead from P, G and cin (no ripple chain); cout = C4.
REQ-019 On each rising clk with rst_n high, sum_q/cout_q SHALL capture the current sum/cout (one-cycle latency).
REQ-020 Combinational outputs SHALL be unaffected by clk and rst_n, including during reset.
REQ-021 Boundaries: 15+15+1 -> sum 15, cout 1; 15+0+1 -> sum 0, cout 1; 0+0+0 -> sum 0, cout 0, pg 0, gg 0.
REQ-022 X/Z on inputs is out of scope; no checking logic required.

Reset
REQ-023 While rst_n is low, sum_q SHALL be 4'h0 and cout_q 0, asserted asynchronously.
REQ-024 Reset asserted mid-operation SHALL clear registered outputs immediately; first capture after deassertion occurs on the next rising clk.

Structure
REQ-025 No shared package is needed; width constant 4 is local.
REQ-026 One sub-module, cla_pg_cell, SHALL generate Pi/Gi for a single bit; four instances feed a lookahead carry unit in the top module.
REQ-027 The registered copy SHALL be a single always block in the top module.

Verification
REQ-028 Exhaustive: cin=0 then cin=1, {in1,in2} swept 0..255, check after 0.1 ns -> {cout,sum} equals in1+in2+cin, zero mismatches.
REQ-029 in1=4'hF, in2=4'hF, cin=1 -> sum=4'hF, cout=1, gg=1, pg=0.
REQ-030 in1=4'hA, in2=4'h5, cin=1 -> sum=4'h0, cout=1, pg=1, gg=0.
REQ-031 rst_n=0, apply 7+8+0 -> sum=4'hF combinationally, sum_q=0, cout_q=0; release reset, one clk edge -> sum_q=4'hF, cout_q=0.
REQ-032 Assert rst_n low between clk edges after capturing 9+9 (sum_q=2, cout_q=1) -> sum_q/cout_q clear immediately without a clk edge.
